// File: rtl/mul_iter_ctrl_if.sv
// Handshake and shared-adder bundle for the iterative multiplier sequencer.
// The slave modport is the sequencer's view, and the master modport is the view from the issue, writeback and adder side.
interface mul_iter_ctrl_if #(
    parameter int XLEN = 64
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            busy;
    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    logic            add_cin;
    logic [XLEN-1:0] add_sum;
    logic            add_cout;

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, out_ready, add_sum, add_cout,
        output in_ready, out_valid, out_result, busy, add_a, add_b, add_cin
    );

    modport master (
        output flush, in_valid, in_op, in_a, in_b, out_ready, add_sum, add_cout,
        input  in_ready, out_valid, out_result, busy, add_a, add_b, add_cin
    );
endinterface

// File: rtl/mul_iter_ctrl.sv
// Shift-add multiplier sequencer for MUL/MULH/MULHSU/MULHU.
// It time-multiplexes one external XLEN-bit adder for three jobs: operand magnitude, per-bit accumulate, and 2*XLEN result negation.
module mul_iter_ctrl #(
    parameter int XLEN = 64
) (
    input logic              clock,
    input logic              reset,
    mul_iter_ctrl_if.slave   bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_ITER,
        S_NEG_LO,
        S_NEG_HI,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_op;
    logic            r_sb;
    logic            r_neg;
    logic            r_c;

    logic            w_accept;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_addA;
    logic [XLEN-1:0] w_addB;
    logic            w_addCin;

    assign w_accept = bus.in_valid & (r_state == S_IDLE) & ~bus.flush;
    assign w_sa     = bus.in_a[XLEN-1] & ((bus.in_op == 2'b01) | (bus.in_op == 2'b10));
    assign w_sb     = bus.in_b[XLEN-1] & (bus.in_op == 2'b01);

    // The adder operands are held at zero in every state that does not use the adder.
    always_comb begin
        w_nextState = r_state;
        w_addA      = '0;
        w_addB      = '0;
        w_addCin    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_nextState = w_sa ? S_ABS_A : (w_sb ? S_ABS_B : S_ITER);
            end
            S_ABS_A: begin
                w_addA      = ~r_mcand;
                w_addCin    = 1'b1;
                w_nextState = r_sb ? S_ABS_B : S_ITER;
            end
            S_ABS_B: begin
                w_addA      = ~r_lo;
                w_addCin    = 1'b1;
                w_nextState = S_ITER;
            end
            S_ITER: begin
                w_addA = r_hi;
                w_addB = r_lo[0] ? r_mcand : '0;
                if (r_cnt == CW'(1))
                    w_nextState = r_neg ? S_NEG_LO : S_DONE;
            end
            S_NEG_LO: begin
                w_addA      = ~r_lo;
                w_addCin    = 1'b1;
                w_nextState = S_NEG_HI;
            end
            S_NEG_HI: begin
                w_addA      = ~r_hi;
                w_addCin    = r_c;
                w_nextState = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready)
                    w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
        if (bus.flush)
            w_nextState = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_sb    <= 1'b0;
            r_neg   <= 1'b0;
            r_c     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand <= bus.in_a;
                        r_hi    <= '0;
                        r_lo    <= bus.in_b;
                        r_cnt   <= CW'(XLEN);
                        r_op    <= bus.in_op;
                        r_sb    <= w_sb;
                        r_neg   <= w_sa ^ w_sb;
                    end
                end
                S_ABS_A: r_mcand <= bus.add_sum;
                S_ABS_B: r_lo    <= bus.add_sum;
                S_ITER: begin
                    // The adder carry-out becomes the new top bit when {hi,lo} shifts right.
                    r_hi  <= {bus.add_cout, bus.add_sum[XLEN-1:1]};
                    r_lo  <= {bus.add_sum[0], r_lo[XLEN-1:1]};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_NEG_LO: begin
                    r_lo <= bus.add_sum;
                    r_c  <= bus.add_cout;
                end
                S_NEG_HI: r_hi <= bus.add_sum;
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE) & ~bus.flush;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.out_result = (r_state == S_DONE) ? ((r_op == 2'b00) ? r_lo : r_hi) : '0;
    assign bus.add_a      = w_addA;
    assign bus.add_b      = w_addB;
    assign bus.add_cin    = w_addCin;
endmodule

// File: doc/mul_iter_ctrl.md
Name: mul_iter_ctrl

Overview:
- Iterative shift-add multiplier sequencer for the EXU RV64M MUL/MULH/MULHSU/MULHU path.
- Does not contain an adder. It owns the operand, accumulator and counter registers and time-multiplexes one external XLEN-bit carry-lookahead adder, built from the add4_PG-style group blocks.
- Per operation it drives that adder through three kinds of pass: operand absolute-value, per-bit accumulate, and 2*XLEN-bit result negation.
- Sits between EXU issue (valid/ready) and writeback (valid/ready).

Parameters:
XLEN, 64, operand and adder width. Counter width is clog2(XLEN)+1.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous kill of any in-flight operation
in_valid  in  1  request valid
in_ready  out  1  high only in IDLE and when flush is low
in_op  in  2  00 MUL (low half), 01 MULH (s×s), 10 MULHSU (s×u), 11 MULHU (u×u)
in_a  in  XLEN  multiplicand
in_b  in  XLEN  multiplier
out_valid  out  1  result valid
out_ready  in  1  writeback accepts
out_result  out  XLEN  MUL: low half; others: high half
busy  out  1  state != IDLE
add_a  out  XLEN  adder operand A
add_b  out  XLEN  adder operand B
add_cin  out  1  adder carry-in
add_sum  in  XLEN  adder sum, combinational from add_a/add_b/add_cin in the same cycle
add_cout  in  1  adder carry-out, combinational

Behaviour:
- Reset: state IDLE; out_valid=0; out_result=0; busy=0; all internal registers 0.
- Adder outputs: add_a, add_b and add_cin are 0 in every state that does not use the adder (IDLE, DONE).
- Accept: in_valid & in_ready. On accept, latch:
  - mcand=in_a, hi=0, lo=in_b, cnt=XLEN.
  - sa = in_a[XLEN-1] & (op==01 | op==10).
  - sb = in_b[XLEN-1] & (op==01).
  - neg = sa ^ sb.
  - MUL always has sa=sb=0.
- States and next-state:
  - IDLE: on accept, go to ABS_A if sa; else ABS_B if sb; else ITER.
  - ABS_A: add_a=~mcand, add_b=0, add_cin=1; mcand<=add_sum. Next: ABS_B if sb, else ITER.
  - ABS_B: add_a=~lo, add_b=0, add_cin=1; lo<=add_sum. Next: ITER.
  - ITER (XLEN cycles):
    - add_a=hi, add_b = lo[0] ? mcand : 0, add_cin=0.
    - {hi,lo} <= {add_cout, add_sum, lo} >> 1, i.e. hi<={add_cout,add_sum[XLEN-1:1]}, lo<={add_sum[0],lo[XLEN-1:1]}.
    - cnt<=cnt-1. When cnt==1: go to NEG_LO if neg, else DONE.
  - NEG_LO: add_a=~lo, add_b=0, add_cin=1; lo<=add_sum; c<=add_cout. Next: NEG_HI.
  - NEG_HI: add_a=~hi, add_b=0, add_cin=c; hi<=add_sum. Next: DONE.
  - DONE: out_valid=1; out_result = (op==00) ? lo : hi. Stable while out_ready=0. On out_ready, go to IDLE next cycle.
- Latency from the accept cycle T to the first out_valid cycle: XLEN+1 + sa + sb + 2·neg.
  - Unsigned: T+XLEN+1.
  - Worst case (sa=1, sb=0, so neg=1): T+XLEN+4.
- Negating a zero product gives zero; no special case is needed.
- Flush: from any state, next state is IDLE and out_valid drops the next cycle. Flush takes priority over in_valid (no accept in that cycle) and over out_ready. A result in DONE that is flushed is lost.
- Reset mid-operation: same as flush, plus all registers return to their reset values.
- Back-to-back: DONE→IDLE costs one cycle. in_ready is high in that IDLE cycle and never during DONE.
- Arithmetic: the {hi,lo} product is exact modulo 2^(2·XLEN) for all op and operand combinations, including sign extremes (most-negative × most-negative under MULH).

Test Plan:
- MUL, a=3, b=5 -> out_result=15; out_valid first asserted exactly 65 cycles after the accept edge (XLEN=64); adder outputs 0 while in IDLE.
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE at T+65. MULH, a=b=-1 -> 0x0 at T+67 (ABS_A and ABS_B taken, no NEG).
- MULH, a=-2, b=3 -> 0xFFFF_FFFF_FFFF_FFFF at T+68. MULHSU, a=-1, b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFF; internal lo=1.
- MULH, a=0x8000_0000_0000_0000, b=same -> 0x4000_0000_0000_0000. MULH, a=-5, b=0 -> 0x0.
- out_ready held low for 10 cycles in DONE -> out_valid and out_result stable throughout. Release out_ready -> in_ready=1 on the following cycle; a back-to-back request is accepted there.
- flush asserted at ITER cycle 20, concurrently with in_valid -> IDLE next cycle, no out_valid, request not accepted. Then a fresh MUL 7×6 -> 42. Repeat with reset instead of flush -> all outputs 0 next cycle.
